// File: rtl/note_arbiter.sv
// rtl/note_arbiter.sv - arbitrates physical-key and UART note requests onto a one-hot note output
//
// Optional feature macro: PIN_PREEMPT_EN (when defined, a valid key press
// during a UART note discards the UART note and plays the key immediately).
//
// Ports:
//   clk           system clock, all state changes on its rising edge
//   rst_n         asynchronous active-low reset
//   pin_req       level, high while a physical key is held
//   pin_note      9-bit key code of the physical key
//   uart_valid    UART note offer, held until accepted
//   uart_note     9-bit UART key code, stable while uart_valid is high
//   uart_ready    combinational accept for the UART offer
//   one_hot_note  registered note, bit k means note k+1, zero means rest
//   src           registered owner: 00 none, 01 pin, 10 UART
//   busy          registered, high whenever the FSM is not idle
//   bad_note      registered one-cycle pulse on an illegal code
`timescale 1ns/1ps
module note_arbiter #(
    parameter int HOLD_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pin_req,
    input  logic [8:0]  pin_note,
    input  logic        uart_valid,
    input  logic [8:0]  uart_note,
    output logic        uart_ready,
    output logic [20:0] one_hot_note,
    output logic [1:0]  src,
    output logic        busy,
    output logic        bad_note
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_PIN  = 2'b01;
    localparam logic [1:0] SRC_UART = 2'b10;

`ifdef PIN_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PIN_PLAY  = 2'd1,
        UART_PLAY = 2'd2,
        GAP       = 2'd3
    } state_t;

    // With no gap configured, a finished note drops straight back to IDLE.
    localparam state_t END_STATE = (GAP_CYCLES > 0) ? GAP : IDLE;

    function automatic logic [20:0] decode(input logic [8:0] code);
        logic [20:0] v;
        v = '0;
        for (int k = 0; k < 21; k++) begin
            if (code == 9'(k + 1)) v[k] = 1'b1;
        end
        return v;
    endfunction

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [8:0]    code_q, code_d;
    logic [20:0]   note_d;
    logic [1:0]    src_d;
    logic          bad_d;
    // Set once an illegal key code has been reported for the current press,
    // so a held illegal key pulses bad_note only once.
    logic          bad_seen, bad_seen_d;

    logic pin_legal, pin_illegal, pin_elig, pin_bad_new;

    assign pin_legal   = (pin_note >= 9'd1) && (pin_note <= 9'd21);
    assign pin_illegal = (pin_note >= 9'd22);
    assign pin_elig    = pin_req && pin_legal;
    assign pin_bad_new = pin_req && pin_illegal && !bad_seen;

    assign uart_ready  = (state == IDLE) && !pin_elig;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        code_d     = code_q;
        note_d     = one_hot_note;
        src_d      = src;
        bad_d      = 1'b0;
        bad_seen_d = pin_req ? bad_seen : 1'b0;

        unique case (state)
            IDLE: begin
                if (pin_elig) begin
                    state_d = PIN_PLAY;
                    note_d  = decode(pin_note);
                    src_d   = SRC_PIN;
                end else begin
                    if (pin_bad_new) begin
                        bad_d      = 1'b1;
                        bad_seen_d = 1'b1;
                    end
                    if (uart_valid) begin
                        if (uart_note <= 9'd21) begin
                            state_d = UART_PLAY;
                            code_d  = uart_note;
                            note_d  = decode(uart_note);
                            src_d   = SRC_UART;
                            cnt_d   = HOLD_LOAD;
                        end else begin
                            bad_d   = 1'b1;
                        end
                    end
                end
            end
            PIN_PLAY: begin
                if (pin_elig) begin
                    note_d = decode(pin_note);
                end else begin
                    // Key lifted, or code moved to rest/illegal: treat as release.
                    if (pin_bad_new) begin
                        bad_d      = 1'b1;
                        bad_seen_d = 1'b1;
                    end
                    state_d = END_STATE;
                    note_d  = '0;
                    src_d   = SRC_NONE;
                    cnt_d   = GAP_LOAD;
                end
            end
            UART_PLAY: begin
                if (PREEMPT && pin_elig) begin
                    state_d = PIN_PLAY;
                    note_d  = decode(pin_note);
                    src_d   = SRC_PIN;
                    cnt_d   = '0;
                end else if (cnt == '0) begin
                    state_d = END_STATE;
                    note_d  = '0;
                    src_d   = SRC_NONE;
                    cnt_d   = GAP_LOAD;
                end else begin
                    note_d  = decode(code_q);
                    cnt_d   = cnt - CNT_ONE;
                end
            end
            GAP: begin
                note_d = '0;
                src_d  = SRC_NONE;
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                note_d  = '0;
                src_d   = SRC_NONE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            code_q       <= '0;
            one_hot_note <= '0;
            src          <= SRC_NONE;
            busy         <= 1'b0;
            bad_note     <= 1'b0;
            bad_seen     <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            code_q       <= code_d;
            one_hot_note <= note_d;
            src          <= src_d;
            busy         <= (state_d != IDLE);
            bad_note     <= bad_d;
            bad_seen     <= bad_seen_d;
        end
    end

endmodule

// File: tb/tb_note_arbiter.sv
// tb/tb_note_arbiter.sv - self-checking bench for note_arbiter (HOLD_CYCLES=8, GAP_CYCLES=2)
`timescale 1ns/1ps
module tb_note_arbiter;

    localparam int HOLD = 8;
    localparam int GAP  = 2;

`ifdef PIN_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pin_req = 1'b0;
    logic [8:0]  pin_note = '0;
    logic        uart_valid = 1'b0;
    logic [8:0]  uart_note = '0;
    logic        uart_ready;
    logic [20:0] one_hot_note;
    logic [1:0]  src;
    logic        busy;
    logic        bad_note;

    logic [24:0] obs;
    assign obs = {one_hot_note, src, busy, bad_note};

    int tests = 0;
    int fails = 0;

    note_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pin_req      (pin_req),
        .pin_note     (pin_note),
        .uart_valid   (uart_valid),
        .uart_note    (uart_note),
        .uart_ready   (uart_ready),
        .one_hot_note (one_hot_note),
        .src          (src),
        .busy         (busy),
        .bad_note     (bad_note)
    );

    always #5 clk = ~clk;

    function automatic int note_bits(input int code);
        return (code >= 1 && code <= 21) ? (1 << (code - 1)) : 0;
    endfunction

    function automatic logic [24:0] expect_out(input int code, input int s, input bit b, input bit bad);
        return {21'(note_bits(code)), 2'(s), b, bad};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] exp;
        #2 rst_n = 1'b0;
        #1;
        exp = expect_out(0, 0, 0, 0);
        if (obs !== exp) begin fails++; $display("FAIL reset_async: got %h exp %h", obs, exp); end
        tests++;
        tick();
        tick();
        if (obs !== exp) begin fails++; $display("FAIL reset_held: got %h exp %h", obs, exp); end
        tests++;
        if (uart_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", uart_ready); end
        tests++;
        rst_n = 1'b1;
        tick();
        if (obs !== exp) begin fails++; $display("FAIL reset_release: got %h exp %h", obs, exp); end
        tests++;
    endtask

    task automatic test_pin_note();
        logic [24:0] exp;
        pin_req = 1'b1;
        pin_note = 9'd5;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = expect_out(5, 1, 1, 0);
            if (obs !== exp) begin fails++; $display("FAIL pin_play[%0d]: got %h exp %h", i, obs, exp); end
            tests++;
        end
        pin_req = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            tick();
            exp = expect_out(0, 0, 1, 0);
            if (obs !== exp) begin fails++; $display("FAIL pin_gap[%0d]: got %h exp %h", i, obs, exp); end
            tests++;
        end
        tick();
        exp = expect_out(0, 0, 0, 0);
        if (obs !== exp) begin fails++; $display("FAIL pin_idle: got %h exp %h", obs, exp); end
        tests++;
    endtask

    task automatic test_uart_note();
        logic [24:0] exp;
        uart_valid = 1'b1;
        uart_note = 9'd21;
        #1;
        if (uart_ready !== 1'b1) begin fails++; $display("FAIL uart_ready_idle: got %b exp 1", uart_ready); end
        tests++;
        tick();
        uart_valid = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            if (i > 0) tick();
            exp = expect_out(21, 2, 1, 0);
            if (obs !== exp) begin fails++; $display("FAIL uart_play[%0d]: got %h exp %h", i, obs, exp); end
            tests++;
        end
        for (int i = 0; i < GAP; i++) begin
            tick();
            exp = expect_out(0, 0, 1, 0);
            if (obs !== exp) begin fails++; $display("FAIL uart_gap[%0d]: got %h exp %h", i, obs, exp); end
            tests++;
        end
        tick();
        exp = expect_out(0, 0, 0, 0);
        if (obs !== exp) begin fails++; $display("FAIL uart_idle: got %h exp %h", obs, exp); end
        tests++;
        if (uart_ready !== 1'b1) begin fails++; $display("FAIL uart_ready_again: got %b exp 1", uart_ready); end
        tests++;
    endtask

    task automatic test_simultaneous();
        logic [24:0] exp;
        pin_req = 1'b1;
        pin_note = 9'd3;
        uart_valid = 1'b1;
        uart_note = 9'd7;
        #1;
        if (uart_ready !== 1'b0) begin fails++; $display("FAIL simul_ready: got %b exp 0", uart_ready); end
        tests++;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = expect_out(3, 1, 1, 0);
            if (obs !== exp) begin fails++; $display("FAIL simul_pin[%0d]: got %h exp %h", i, obs, exp); end
            tests++;
            if (uart_ready !== 1'b0) begin fails++; $display("FAIL simul_hold[%0d]: got %b exp 0", i, uart_ready); end
            tests++;
        end
        pin_req = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            tick();
            exp = expect_out(0, 0, 1, 0);
            if (obs !== exp) begin fails++; $display("FAIL simul_gap[%0d]: got %h exp %h", i, obs, exp); end
            tests++;
        end
        tick();
        if (uart_ready !== 1'b1) begin fails++; $display("FAIL simul_ready_idle: got %b exp 1", uart_ready); end
        tests++;
        tick();
        uart_valid = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            if (i > 0) tick();
            exp = expect_out(7, 2, 1, 0);
            if (obs !== exp) begin fails++; $display("FAIL simul_uart[%0d]: got %h exp %h", i, obs, exp); end
            tests++;
        end
        repeat (GAP + 1) tick();
    endtask

    task automatic test_bad_uart();
        logic [24:0] exp;
        uart_valid = 1'b1;
        uart_note = 9'd30;
        #1;
        if (uart_ready !== 1'b1) begin fails++; $display("FAIL bad_uart_ready: got %b exp 1", uart_ready); end
        tests++;
        tick();
        uart_valid = 1'b0;
        exp = expect_out(0, 0, 0, 1);
        if (obs !== exp) begin fails++; $display("FAIL bad_uart_pulse: got %h exp %h", obs, exp); end
        tests++;
        tick();
        exp = expect_out(0, 0, 0, 0);
        if (obs !== exp) begin fails++; $display("FAIL bad_uart_after: got %h exp %h", obs, exp); end
        tests++;
    endtask

    task automatic test_bad_pin();
        logic [24:0] exp;
        pin_req = 1'b1;
        pin_note = 9'd100;
        tick();
        exp = expect_out(0, 0, 0, 1);
        if (obs !== exp) begin fails++; $display("FAIL bad_pin_pulse: got %h exp %h", obs, exp); end
        tests++;
        tick();
        exp = expect_out(0, 0, 0, 0);
        if (obs !== exp) begin fails++; $display("FAIL bad_pin_once: got %h exp %h", obs, exp); end
        tests++;
        pin_req = 1'b0;
        tick();
        pin_req = 1'b1;
        pin_note = 9'd511;
        tick();
        exp = expect_out(0, 0, 0, 1);
        if (obs !== exp) begin fails++; $display("FAIL bad_pin_repress: got %h exp %h", obs, exp); end
        tests++;
        pin_req = 1'b0;
        tick();
    endtask

    task automatic test_preempt();
        logic [24:0] exp;
        uart_valid = 1'b1;
        uart_note = 9'd7;
        tick();
        uart_valid = 1'b0;
        tick();
        tick();
        pin_req = 1'b1;
        pin_note = 9'd9;
        tick();
        if (PREEMPT) begin
            exp = expect_out(9, 1, 1, 0);
            if (obs !== exp) begin fails++; $display("FAIL preempt_now: got %h exp %h", obs, exp); end
            tests++;
        end else begin
            for (int i = 3; i < HOLD; i++) begin
                if (i > 3) tick();
                exp = expect_out(7, 2, 1, 0);
                if (obs !== exp) begin fails++; $display("FAIL preempt_uart[%0d]: got %h exp %h", i, obs, exp); end
                tests++;
            end
            for (int i = 0; i < GAP; i++) begin
                tick();
                exp = expect_out(0, 0, 1, 0);
                if (obs !== exp) begin fails++; $display("FAIL preempt_gap[%0d]: got %h exp %h", i, obs, exp); end
                tests++;
            end
            tick();
            exp = expect_out(0, 0, 0, 0);
            if (obs !== exp) begin fails++; $display("FAIL preempt_idle: got %h exp %h", obs, exp); end
            tests++;
            tick();
            exp = expect_out(9, 1, 1, 0);
            if (obs !== exp) begin fails++; $display("FAIL preempt_served: got %h exp %h", obs, exp); end
            tests++;
        end
        pin_req = 1'b0;
        repeat (GAP + 1) tick();
    endtask

    task automatic test_async_reset();
        logic [24:0] exp;
        uart_valid = 1'b1;
        uart_note = 9'd21;
        tick();
        uart_valid = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        exp = expect_out(0, 0, 0, 0);
        if (obs !== exp) begin fails++; $display("FAIL areset_zero: got %h exp %h", obs, exp); end
        tests++;
        if (uart_ready !== 1'b1) begin fails++; $display("FAIL areset_ready: got %b exp 1", uart_ready); end
        tests++;
        tick();
        rst_n = 1'b1;
        tick();
        if (obs !== exp) begin fails++; $display("FAIL areset_nogap: got %h exp %h", obs, exp); end
        tests++;
        uart_valid = 1'b1;
        uart_note = 9'd1;
        tick();
        uart_valid = 1'b0;
        exp = expect_out(1, 2, 1, 0);
        if (obs !== exp) begin fails++; $display("FAIL areset_first_edge: got %h exp %h", obs, exp); end
        tests++;
        repeat (HOLD + GAP + 1) tick();
    endtask

    function automatic logic [8:0] rand_code();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 9'd0;
        if (r == 1) return 9'($urandom_range(22, 511));
        return 9'($urandom_range(1, 21));
    endfunction

    task automatic test_random();
        bit m_pin, m_rep, m_bad, rep_next, idle, pin_ok, pin_bad, exp_ready, accepted;
        int m_uart_left, m_gap_left, m_code, exp_src;
        logic [24:0] exp;
        m_pin = 0; m_rep = 0; m_bad = 0;
        m_uart_left = 0; m_gap_left = 0; m_code = 0;
        accepted = 0;
        pin_req = 0; uart_valid = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (accepted) uart_valid = 1'b0;
            if ($urandom_range(0, 11) == 0) pin_req = ~pin_req;
            if (pin_req && $urandom_range(0, 7) == 0) pin_note = rand_code();
            if (!uart_valid && $urandom_range(0, 7) == 0) begin
                uart_valid = 1'b1;
                uart_note = rand_code();
            end
            #1;
            idle      = !m_pin && m_uart_left == 0 && m_gap_left == 0;
            pin_ok    = pin_req && pin_note >= 1 && pin_note <= 21;
            pin_bad   = pin_req && pin_note >= 22;
            exp_ready = idle && !pin_ok;
            if (uart_ready !== exp_ready) begin fails++; $display("FAIL rand_ready[%0d]: got %b exp %b", cyc, uart_ready, exp_ready); end
            tests++;
            accepted = uart_valid && exp_ready;
            m_bad = 0;
            rep_next = pin_req ? m_rep : 1'b0;
            if (idle) begin
                if (pin_ok) begin
                    m_pin = 1; m_code = int'(pin_note);
                end else begin
                    if (pin_bad && !m_rep) begin m_bad = 1; rep_next = 1; end
                    if (uart_valid) begin
                        if (uart_note <= 21) begin m_uart_left = HOLD; m_code = int'(uart_note); end
                        else m_bad = 1;
                    end
                end
            end else if (m_pin) begin
                if (pin_ok) m_code = int'(pin_note);
                else begin
                    if (pin_bad && !m_rep) begin m_bad = 1; rep_next = 1; end
                    m_pin = 0; m_gap_left = GAP;
                end
            end else if (m_uart_left > 0) begin
                if (PREEMPT && pin_ok) begin
                    m_uart_left = 0; m_pin = 1; m_code = int'(pin_note);
                end else begin
                    m_uart_left--;
                    if (m_uart_left == 0) m_gap_left = GAP;
                end
            end else begin
                m_gap_left--;
            end
            m_rep = rep_next;
            exp_src = m_pin ? 1 : (m_uart_left > 0 ? 2 : 0);
            exp = expect_out((exp_src != 0) ? m_code : 0, exp_src,
                             m_pin || m_uart_left > 0 || m_gap_left > 0, m_bad);
            tick();
            if (obs !== exp) begin fails++; $display("FAIL rand_out[%0d]: got %h exp %h", cyc, obs, exp); end
            tests++;
        end
        pin_req = 1'b0;
        uart_valid = 1'b0;
        repeat (HOLD + GAP + 2) tick();
    endtask

    initial begin
        test_reset();
        test_pin_note();
        test_uart_note();
        test_simultaneous();
        test_bad_uart();
        test_bad_pin();
        test_preempt();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
